// File: rtl/mrd_wr_pkg.sv
// Shared constants and types for the write-back stage of the radix/twiddle datapath.
// Lane records carry the target bank, the bank address and the complex sample.
package mrd_wr_pkg;
   localparam int NB    = 5;
   localparam int wD    = 18;
   localparam int wAddr = 8;
   localparam int wCnt  = 12;
   localparam int BIW   = 3;
   localparam logic [BIW-1:0] NB_IDX = BIW'(NB);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic [BIW-1:0]          bank_index;
      logic [wAddr-1:0]        bank_addr;
      logic signed [wD-1:0]    d_real;
      logic signed [wD-1:0]    d_imag;
   } lane_t;
endpackage

// File: rtl/mrd_wr_xbar.sv
// Combinational lane-to-bank priority crossbar; the lowest-numbered lane wins a bank.
// Also flags bank collisions and out-of-range bank indices for the current beat.
module mrd_wr_xbar
   import mrd_wr_pkg::*;
(
   input  lane_t                i_lane [NB],
   output logic [NB-1:0]        o_en,
   output logic [wAddr-1:0]     o_addr [NB],
   output logic [2*wD-1:0]      o_data [NB],
   output logic                 o_collision,
   output logic                 o_index_err
);
   always_comb begin
      o_en        = '0;
      o_collision = 1'b0;
      o_index_err = 1'b0;
      for (int b = 0; b < NB; b++) begin
         o_addr[b] = '0;
         o_data[b] = '0;
      end
      // Scanning lanes in ascending order gives lane priority by construction.
      for (int i = 0; i < NB; i++) begin
         if (i_lane[i].bank_index >= NB_IDX) o_index_err = 1'b1;
         for (int b = 0; b < NB; b++) begin
            if (i_lane[i].bank_index == BIW'(b)) begin
               if (o_en[b]) begin
                  o_collision = 1'b1;
               end else begin
                  o_en[b]   = 1'b1;
                  o_addr[b] = i_lane[i].bank_addr;
                  o_data[b] = {i_lane[i].d_imag, i_lane[i].d_real};
               end
            end
         end
      end
   end
endmodule

// File: rtl/mrd_stage_wr.sv
// Write-back stage: counts beats per FFT stage, routes 5 lanes to 5 banks through a
// registered crossbar (2-cycle latency), latches the stage exponent and flags errors.
module mrd_stage_wr
   import mrd_wr_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   sop,
   input  logic [wCnt-1:0]        stage_len,
   input  logic                   in_valid,
   input  logic [NB*BIW-1:0]      in_bank_index,
   input  logic [NB*wAddr-1:0]    in_bank_addr,
   input  logic [NB*wD-1:0]       in_d_real,
   input  logic [NB*wD-1:0]       in_d_imag,
   input  logic [3:0]             in_exp,
   output logic [NB-1:0]          wr_en,
   output logic [NB*wAddr-1:0]    wr_addr,
   output logic [NB*2*wD-1:0]     wr_data,
   output logic                   busy,
   output logic                   stage_done,
   output logic [3:0]             exp_out,
   output logic [wCnt-1:0]        beat_cnt,
   output logic                   err_collision,
   output logic                   err_index,
   output logic                   err_unexpected
);
   state_t              r_state, w_state_nxt;
   logic [wCnt-1:0]     r_len, r_cnt, w_len_eff, w_cnt_nxt;
   logic [3:0]          r_exp;
   logic                r_err_coll, r_err_idx, r_err_unexp;
   logic                w_acc, w_final;
   lane_t               w_lane [NB];
   lane_t               r_lane_p1 [NB];
   logic                r_vld_p1, r_last_p1;
   logic [NB-1:0]       r_wr_en, w_xb_en;
   logic [wAddr-1:0]    r_wr_addr [NB], w_xb_addr [NB];
   logic [2*wD-1:0]     r_wr_data [NB], w_xb_data [NB];
   logic                r_done, w_xb_coll, w_xb_idx;

   // A beat arriving with sop belongs to the new stage, so sop also counts as "in RUN".
   assign w_acc     = in_valid && (sop || (r_state == RUN));
   assign w_len_eff = sop ? stage_len : r_len;
   assign w_cnt_nxt = (sop ? '0 : r_cnt) + wCnt'(1);
   assign w_final   = w_acc && (w_cnt_nxt >= w_len_eff);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (sop) begin
         w_state_nxt = w_final ? DONE : RUN;
      end else begin
         case (r_state)
            RUN:     if (w_final) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      busy = (r_state == RUN);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_len       <= '0;
         r_cnt       <= '0;
         r_exp       <= '0;
         r_err_unexp <= 1'b0;
      end else begin
         if (sop) begin
            r_len <= stage_len;
            r_cnt <= w_acc ? wCnt'(1) : '0;
         end else if (w_acc) begin
            r_cnt <= w_cnt_nxt;
         end
         if (w_final) r_exp <= in_exp;
         r_err_unexp <= sop ? 1'b0 : (r_err_unexp | (in_valid & ~w_acc));
      end
   end

   always_comb begin
      for (int i = 0; i < NB; i++) begin
         w_lane[i].bank_index = in_bank_index[i*BIW +: BIW];
         w_lane[i].bank_addr  = in_bank_addr[i*wAddr +: wAddr];
         w_lane[i].d_real     = in_d_real[i*wD +: wD];
         w_lane[i].d_imag     = in_d_imag[i*wD +: wD];
      end
   end

   // Stage 1: capture accepted beats.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld_p1  <= 1'b0;
         r_last_p1 <= 1'b0;
         for (int i = 0; i < NB; i++) r_lane_p1[i] <= '0;
      end else begin
         r_vld_p1  <= w_acc;
         r_last_p1 <= w_final;
         if (w_acc) begin
            for (int i = 0; i < NB; i++) r_lane_p1[i] <= w_lane[i];
         end
      end
   end

   mrd_wr_xbar u_xbar (
      .i_lane      (r_lane_p1),
      .o_en        (w_xb_en),
      .o_addr      (w_xb_addr),
      .o_data      (w_xb_data),
      .o_collision (w_xb_coll),
      .o_index_err (w_xb_idx)
   );

   // Stage 2: register crossbar result; untargeted banks hold address/data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_en    <= '0;
         r_done     <= 1'b0;
         r_err_coll <= 1'b0;
         r_err_idx  <= 1'b0;
         for (int b = 0; b < NB; b++) begin
            r_wr_addr[b] <= '0;
            r_wr_data[b] <= '0;
         end
      end else begin
         r_wr_en    <= r_vld_p1 ? w_xb_en : '0;
         r_done     <= r_last_p1 && !sop;
         r_err_coll <= sop ? 1'b0 : (r_err_coll | (r_vld_p1 & w_xb_coll));
         r_err_idx  <= sop ? 1'b0 : (r_err_idx | (r_vld_p1 & w_xb_idx));
         for (int b = 0; b < NB; b++) begin
            if (r_vld_p1 && w_xb_en[b]) begin
               r_wr_addr[b] <= w_xb_addr[b];
               r_wr_data[b] <= w_xb_data[b];
            end
         end
      end
   end

   for (genvar b = 0; b < NB; b++) begin : g_flat
      assign wr_addr[b*wAddr +: wAddr] = r_wr_addr[b];
      assign wr_data[b*2*wD +: 2*wD]   = r_wr_data[b];
   end

   assign wr_en          = r_wr_en;
   assign stage_done     = r_done;
   assign exp_out        = r_exp;
   assign beat_cnt       = r_cnt;
   assign err_collision  = r_err_coll;
   assign err_index      = r_err_idx;
   assign err_unexpected = r_err_unexp;
endmodule
